et_demux1x2: RTL

Edge-triggered 1-to-2 demultiplexer, the receive-side counterpart of the 2x1 edge-triggered mux. It routes one valid/ready input stream to output A or B according to `sel`, sampled on the accepting clock edge. Each output has a small registered FIFO, so a stalled consumer on one side never corrupts data already queued for the other side. The block sits downstream of the mux wherever a shared lane is split back into two consumers.

---
 rtl/et_demux1x2_pkg.sv | 17 +
 rtl/et_demux1x2_fifo.sv | 65 ++++++
 rtl/et_demux1x2.sv | 67 ++++++
 3 files changed

// File: rtl/et_demux1x2_pkg.sv
// Shared definitions for the edge-triggered 1-to-2 demultiplexer.
//   sel_e : destination encoding carried on the sel input
//           SEL_A (0) routes to output A, SEL_B (1) routes to output B.
package et_demux1x2_pkg;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

  // Occupancy counters need one bit more than the pointers so that they
  // can represent a completely full FIFO.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/et_demux1x2_fifo.sv
// et_fifo: small registered FIFO used on each demux output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_data     : write request and word (ignored while full)
//   pop                 : consumer takes the head (ignored while empty)
//   valid, pop_data     : head present / head word (0 while empty)
//   full, count         : occupancy flags, count in 0..DEPTH
// DEPTH must be a power of two, 2 or greater, so the pointers wrap for free.
module et_fifo
  import et_demux1x2_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic [count_w(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // No bypass: a pop in the same cycle does not open room for a push.
  assign do_push = push & ~full;
  // No fall-through: a push into an empty FIFO is not poppable this cycle.
  assign do_pop  = pop & valid;

  assign full  = (count == CW'(DEPTH));
  assign valid = (count != '0);
  // Gating with valid keeps the output at 0 after reset without having to
  // clear the storage array.
  assign pop_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/et_demux1x2.sv
// et_demux1x2: routes one valid/ready stream to output A or B.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_valid, in_ready, in_data : input stream
//   sel                         : destination sampled on the accepting edge
//   a_valid, a_ready, a_data    : output stream A, a_count its occupancy
//   b_valid, b_ready, b_data    : output stream B, b_count its occupancy
// Each output owns a FIFO, so a stall on one side never blocks the other.
module et_demux1x2
  import et_demux1x2_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      sel,
  output logic                      a_valid,
  input  logic                      a_ready,
  output logic [WIDTH-1:0]          a_data,
  output logic [count_w(DEPTH)-1:0] a_count,
  output logic                      b_valid,
  input  logic                      b_ready,
  output logic [WIDTH-1:0]          b_data,
  output logic [count_w(DEPTH)-1:0] b_count
);

  logic a_full;
  logic b_full;
  logic accept;
  logic push_a;
  logic push_b;

  // Only the selected FIFO can block the input; depends on sel and the
  // registered occupancy, never on the consumer readies.
  assign in_ready = (sel == SEL_B) ? ~b_full : ~a_full;
  assign accept   = in_valid & in_ready;
  assign push_a   = accept & (sel == SEL_A);
  assign push_b   = accept & (sel == SEL_B);

  et_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_a),
    .push_data (in_data),
    .pop       (a_ready),
    .valid     (a_valid),
    .pop_data  (a_data),
    .full      (a_full),
    .count     (a_count)
  );

  et_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_b),
    .push_data (in_data),
    .pop       (b_ready),
    .valid     (b_valid),
    .pop_data  (b_data),
    .full      (b_full),
    .count     (b_count)
  );

endmodule
